shift_arbiter: RTL

SHIFT_ARBITER -- requirements
Module: shift_arbiter

---
 rtl/shift_arbiter.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/shift_arbiter.sv
// Two-requester round-robin arbiter in front of one shared shift datapath.
// A captured request runs through EXEC for one cycle and its result is held in HOLD until taken.

module sll (
    input  logic [31:0] data,
    input  logic [4:0]  shiftamt,
    output logic [31:0] out
);
    assign out = data << shiftamt;
endmodule

module sra (
    input  logic [31:0] data,
    input  logic [4:0]  shiftamt,
    output logic [31:0] out
);
    assign out = $unsigned($signed(data) >>> shiftamt);
endmodule

module shift_arbiter (
    input  logic        clock,
    input  logic        reset,
    input  logic        req0,
    input  logic        op0,
    input  logic [31:0] data0,
    input  logic [4:0]  shiftamt0,
    input  logic        req1,
    input  logic        op1,
    input  logic [31:0] data1,
    input  logic [4:0]  shiftamt1,
    output logic        ack0,
    output logic        ack1,
    output logic [31:0] out,
    output logic        out_valid,
    output logic        out_id,
    input  logic        out_taken,
    output logic        busy
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    logic [1:0]  state_r;
    logic        last_grant_r;
    logic        op_r;
    logic [31:0] data_r;
    logic [4:0]  amt_r;
    logic        id_r;
    logic        ack0_r;
    logic        ack1_r;
    logic [31:0] out_r;
    logic        out_valid_r;
    logic        out_id_r;
    logic        busy_r;

    logic        grant_s;
    logic [31:0] sll_out_s;
    logic [31:0] sra_out_s;
    logic [31:0] result_s;

    sll u_sll (.data(data_r), .shiftamt(amt_r), .out(sll_out_s));
    sra u_sra (.data(data_r), .shiftamt(amt_r), .out(sra_out_s));

    // Round-robin pick: on a tie the requester that did not win last time is served.
    always_comb begin
        grant_s = 1'b0;
        if (req0 && req1) begin
            grant_s = ~last_grant_r;
        end else if (req1) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
    end

    // Select the shifter output matching the captured operation.
    always_comb begin
        result_s = 32'd0;
        if (op_r) begin
            result_s = sra_out_s;
        end else begin
            result_s = sll_out_s;
        end
    end

    // Control FSM, operand capture and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            last_grant_r <= 1'b1;
            op_r         <= 1'b0;
            data_r       <= 32'd0;
            amt_r        <= 5'd0;
            id_r         <= 1'b0;
            ack0_r       <= 1'b0;
            ack1_r       <= 1'b0;
            out_r        <= 32'd0;
            out_valid_r  <= 1'b0;
            out_id_r     <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            ack0_r <= 1'b0;
            ack1_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (req0 || req1) begin
                        id_r         <= grant_s;
                        last_grant_r <= grant_s;
                        if (grant_s) begin
                            op_r   <= op1;
                            data_r <= data1;
                            amt_r  <= shiftamt1;
                            ack1_r <= 1'b1;
                        end else begin
                            op_r   <= op0;
                            data_r <= data0;
                            amt_r  <= shiftamt0;
                            ack0_r <= 1'b1;
                        end
                        state_r <= EXEC;
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                EXEC: begin
                    out_r       <= result_s;
                    out_valid_r <= 1'b1;
                    out_id_r    <= id_r;
                    state_r     <= HOLD;
                    busy_r      <= 1'b1;
                end
                HOLD: begin
                    // A HOLD without a valid result can only come from corruption; drop back to IDLE.
                    if ((out_valid_r && out_taken) || !out_valid_r) begin
                        out_valid_r <= 1'b0;
                        state_r     <= IDLE;
                        busy_r      <= 1'b0;
                    end else begin
                        state_r <= HOLD;
                        busy_r  <= 1'b1;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    state_r     <= IDLE;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign ack0      = ack0_r;
    assign ack1      = ack1_r;
    assign out       = out_r;
    assign out_valid = out_valid_r;
    assign out_id    = out_id_r;
    assign busy      = busy_r;
endmodule
